dmem_interface: RTL



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_wbuf.sv | 76 +++++++
 rtl/dmem_interface.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory port adapter
// Contents: write-buffer entry struct, read-path FSM state enum, full byte mask.
package dmem_pkg;

    // Word-address width of a stored entry (byte address bits [31:2]).
    localparam int WB_AW = 30;

    localparam logic [3:0] MASK_FULL = 4'hF;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [3:0]       mask;
        logic [31:0]      data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT
    } rd_state_t;

endpackage

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - posted-store FIFO with parallel address match
// Ports:
//   clk_in, rst_in       clock, asynchronous active-high reset
//   push, push_entry     enqueue one store at the tail
//   pop                  dequeue the head entry
//   head                 oldest entry (valid when !empty)
//   full, empty          occupancy flags
//   lookup_addr          word address compared against every valid entry
//   hit                  some valid entry matches lookup_addr
//   young_mask/data      mask and data of the youngest matching entry
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    input  logic [WB_AW-1:0] lookup_addr,
    output logic             hit,
    output logic [3:0]       young_mask,
    output logic [31:0]      young_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_entry;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_q[head_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Walk from oldest to youngest so the last match written wins.
    always_comb begin
        hit        = 1'b0;
        young_mask = '0;
        young_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (mem_q[head_q + PW'(i)].addr == lookup_addr)) begin
                hit        = 1'b1;
                young_mask = mem_q[head_q + PW'(i)].mask;
                young_data = mem_q[head_q + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/dmem_interface.sv
// rtl/dmem_interface.sv - core data port to req/gnt/rvalid SRAM bus adapter
// Optional feature macro: DMEM_FWD_EN (store-to-load forwarding from a full-mask
// youngest buffer match).
// Ports:
//   clk_in, rst_in                      clock, asynchronous active-high reset
//   dmaddr_in/dmdata_in/dmwr_mask_in    core address, store data, byte lanes
//   dmwr_req_in, dmrd_req_in            store / load request
//   dmdata_out, stall_out               load word, core hold
//   mem_req_out/we/addr/wmask/wdata     bus request side
//   mem_gnt_in, mem_rvalid_in, mem_rdata_in  bus response side
module dmem_interface
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 30
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [31:0]   dmaddr_in,
    input  logic [31:0]   dmdata_in,
    input  logic [3:0]    dmwr_mask_in,
    input  logic          dmwr_req_in,
    input  logic          dmrd_req_in,
    output logic [31:0]   dmdata_out,
    output logic          stall_out,
    output logic          mem_req_out,
    output logic          mem_we_out,
    output logic [AW-1:0] mem_addr_out,
    output logic [3:0]    mem_wmask_out,
    output logic [31:0]   mem_wdata_out,
    input  logic          mem_gnt_in,
    input  logic          mem_rvalid_in,
    input  logic [31:0]   mem_rdata_in
);

    rd_state_t        state_q, state_d;
    logic [AW-1:0]    rd_addr_q;
    logic [31:0]      rdata_q;
    logic             wr_hold_q, wr_hold_d;

    logic [WB_AW-1:0] word_addr;
    wb_entry_t        push_entry, head;
    logic             full, empty, hit, push, pop;
    logic [3:0]       young_mask;
    logic [31:0]      young_data;
    logic             store_req, load, fwd, rd_issue;
    logic             unused_lsb;

    assign word_addr  = dmaddr_in[31:2];
    assign unused_lsb = ^dmaddr_in[1:0];
    assign load       = dmrd_req_in;
    // A load in the same cycle wins; an all-zero mask writes nothing.
    assign store_req  = dmwr_req_in && !dmrd_req_in && (dmwr_mask_in != 4'h0);
    assign push_entry = '{addr: word_addr, mask: dmwr_mask_in, data: dmdata_in};
    assign push       = store_req && !stall_out && !full;

`ifdef DMEM_FWD_EN
    assign fwd        = (state_q == IDLE) && load && hit && (young_mask == MASK_FULL);
    assign dmdata_out = fwd ? young_data : rdata_q;
`else
    logic unused_fwd;
    assign fwd        = 1'b0;
    assign unused_fwd = ^{young_mask, young_data};
    assign dmdata_out = rdata_q;
`endif

    dmem_wbuf #(.DEPTH(DEPTH)) u_wbuf (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .lookup_addr (word_addr),
        .hit         (hit),
        .young_mask  (young_mask),
        .young_data  (young_data)
    );

    always_comb begin
        state_d       = state_q;
        wr_hold_d     = 1'b0;
        rd_issue      = 1'b0;
        pop           = 1'b0;
        stall_out     = 1'b0;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wmask_out = '0;
        mem_wdata_out = '0;
        case (state_q)
            IDLE: begin
                // A write left ungranted on the bus keeps it, so a clean load waits.
                if (load && !hit && !wr_hold_q) begin
                    rd_issue     = 1'b1;
                    mem_req_out  = 1'b1;
                    mem_addr_out = word_addr[AW-1:0];
                    stall_out    = 1'b1;
                    state_d      = mem_gnt_in ? RD_WAIT : RD_REQ;
                end else begin
                    if (load && !fwd) begin
                        stall_out = 1'b1;
                    end
                    if (!empty) begin
                        mem_req_out   = 1'b1;
                        mem_we_out    = 1'b1;
                        mem_addr_out  = head.addr[AW-1:0];
                        mem_wmask_out = head.mask;
                        mem_wdata_out = head.data;
                        pop           = mem_gnt_in;
                        wr_hold_d     = !mem_gnt_in;
                    end
                end
                if (store_req && full) begin
                    stall_out = 1'b1;
                end
            end
            RD_REQ: begin
                mem_req_out  = 1'b1;
                mem_addr_out = rd_addr_q;
                stall_out    = 1'b1;
                if (mem_gnt_in) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall_out = !mem_rvalid_in;
                if (mem_rvalid_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            wr_hold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_hold_q <= wr_hold_d;
            if (rd_issue) begin
                rd_addr_q <= word_addr[AW-1:0];
            end
            if ((state_q == RD_WAIT) && mem_rvalid_in) begin
                rdata_q <= mem_rdata_in;
            end
        end
    end

    // The core never issues a load and a store together.
    a_no_ld_st: assert property (@(posedge clk_in) disable iff (rst_in)
        !(dmrd_req_in && dmwr_req_in));

endmodule
